// File: rtl/serial_compare_if.sv
// Handshake and operand bundle for the bit-serial magnitude comparator.
// The bench drives the master side; the comparator is the slave.
interface serial_compare_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic             ready;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output start, sgn, p, q,
        input  ready, done, gt, lt, eq
    );

    modport slave (
        input  start, sgn, p, q,
        output ready, done, gt, lt, eq
    );
endinterface

// File: rtl/serial_compare.sv
// Bit-serial comparator: scans P and Q MSB first, stops at the first differing
// bit, and reports gt/lt/eq with a registered one-cycle done pulse.
module serial_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_compare_if.slave  cmp
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sgn_q, sgn_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             done_q, done_d;

    logic p_msb;
    logic q_msb;
    logic sign_pos;

    assign p_msb    = p_q[WIDTH-1];
    assign q_msb    = q_q[WIDTH-1];
    // In signed mode the first bit scanned carries negative weight, inverting the rule.
    assign sign_pos = sgn_q && (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        sgn_d   = sgn_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    p_d     = cmp.p;
                    q_d     = cmp.q;
                    sgn_d   = cmp.sgn;
                    cnt_d   = CNT_MAX;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                p_d = {p_q[WIDTH-2:0], 1'b0};
                q_d = {q_q[WIDTH-2:0], 1'b0};
                if (p_msb != q_msb) begin
                    if (p_msb ^ sign_pos) begin
                        gt_d = 1'b1;
                    end else begin
                        lt_d = 1'b1;
                    end
                    state_d = FIN;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIN: begin
                // done is registered, so the pulse lands in the cycle after FIN.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            sgn_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            sgn_q   <= sgn_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
        end
    end

    assign cmp.ready = (state_q == IDLE);
    assign cmp.done  = done_q;
    assign cmp.gt    = gt_q;
    assign cmp.lt    = lt_q;
    assign cmp.eq    = eq_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed and random checks of serial_compare at WIDTH=8: latency, flags,
// start masking, operand isolation, reset abort and back-to-back operation.
module tb_serial_compare;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_compare_if #(.WIDTH(W)) bus ();

    serial_compare #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: latency from the first differing bit, flags from a native compare.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return (W - i) + 1;
        end
        return W + 1;
    endfunction

    function automatic logic [2:0] exp_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b010;
            return 3'b001;
        end
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [2:0] flags();
        return {bus.gt, bus.lt, bus.eq};
    endfunction

    // Presents one start, then scrambles the operands to prove they were latched.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.start = 1'b1;
        bus.p     = a;
        bus.q     = b;
        bus.sgn   = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.p     = W'($urandom);
        bus.q     = W'($urandom);
        bus.sgn   = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 2 * W + 4; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.p     = '0;
        bus.q     = '0;
        #1;
        n_cmp++;
        if ({bus.ready, bus.done, flags()} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 10000", {bus.ready, bus.done, flags()});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.ready, bus.done, flags()} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 10000", {bus.ready, bus.done, flags()});
        end
    endtask

    task automatic test_msb_decides();
        int lat;
        launch(8'h80, 8'h7F, 1'b0);
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ready: got %b want 0", bus.ready);
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL unsigned_msb_lat: got %0d want 2", lat);
        end
        n_cmp++;
        if (flags() !== 3'b100) begin
            n_bad++;
            $display("FAIL unsigned_msb_flags: got %b want 100", flags());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_one_cycle: got %b want 0", bus.done);
        end
    endtask

    task automatic test_signed();
        int lat;
        launch(8'h80, 8'h7F, 1'b1);
        wait_done(lat);
        n_cmp++;
        if (lat !== 2 || flags() !== 3'b010) begin
            n_bad++;
            $display("FAIL signed_msb: got lat %0d flags %b want lat 2 flags 010", lat, flags());
        end
        launch(8'h03, 8'h02, 1'b0);
        wait_done(lat);
        n_cmp++;
        if (lat !== 9 || flags() !== 3'b100) begin
            n_bad++;
            $display("FAIL lsb_decides: got lat %0d flags %b want lat 9 flags 100", lat, flags());
        end
        launch(8'h7F, 8'hFF, 1'b1);
        wait_done(lat);
        n_cmp++;
        if (lat !== 2 || flags() !== 3'b100) begin
            n_bad++;
            $display("FAIL signed_pos_vs_neg: got lat %0d flags %b want lat 2 flags 100", lat, flags());
        end
        launch(8'hFE, 8'hFF, 1'b1);
        wait_done(lat);
        n_cmp++;
        if (lat !== 9 || flags() !== 3'b010) begin
            n_bad++;
            $display("FAIL signed_both_neg: got lat %0d flags %b want lat 9 flags 010", lat, flags());
        end
    endtask

    task automatic test_equal_hold();
        int lat;
        launch(8'h5A, 8'h5A, 1'b0);
        wait_done(lat);
        n_cmp++;
        if (lat !== 9 || flags() !== 3'b001) begin
            n_bad++;
            $display("FAIL equal: got lat %0d flags %b want lat 9 flags 001", lat, flags());
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.done, flags()} !== 4'b0001) begin
            n_bad++;
            $display("FAIL flags_held: got %b want 0001", {bus.done, flags()});
        end
        launch(8'h01, 8'h00, 1'b0);
        n_cmp++;
        if (flags() !== 3'b000) begin
            n_bad++;
            $display("FAIL flags_cleared: got %b want 000", flags());
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== 9 || flags() !== 3'b100) begin
            n_bad++;
            $display("FAIL after_equal: got lat %0d flags %b want lat 9 flags 100", lat, flags());
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        int lat;
        ndone = 0;
        lat   = 0;
        launch(8'h01, 8'h02, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            if (n == 2) begin
                bus.start = 1'b1;
                bus.p     = 8'hFF;
                bus.q     = 8'h00;
                bus.sgn   = 1'b0;
            end
            if (n == 3) bus.start = 1'b0;
            if (n == 9) begin
                n_cmp++;
                if (flags() !== 3'b010) begin
                    n_bad++;
                    $display("FAIL ignored_start_flags: got %b want 010", flags());
                end
            end
        end
        n_cmp++;
        if (ndone !== 1 || lat !== 8) begin
            n_bad++;
            $display("FAIL ignored_start_done: got %0d pulses lat %0d want 1 pulse lat 8", ndone, lat);
        end
    endtask

    task automatic test_reset_abort();
        int ndone;
        int lat;
        launch(8'h01, 8'h02, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ready, bus.done, flags()} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort_scan_state: got %b want 10000", {bus.ready, bus.done, flags()});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL abort_scan_done: got %0d pulses want 0", ndone);
        end
        launch(8'h10, 8'h20, 1'b0);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || flags() !== 3'b010) begin
            n_bad++;
            $display("FAIL after_abort: got lat %0d flags %b want lat 4 flags 010", lat, flags());
        end
        // Abort while in FIN: the pending done pulse must be suppressed.
        launch(8'h80, 8'h7F, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ready, bus.done, flags()} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort_fin_state: got %b want 10000", {bus.ready, bus.done, flags()});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL abort_fin_done: got %0d pulses want 0", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] a [4] = '{8'hC3, 8'h00, 8'h40, 8'hAA};
        logic [W-1:0] b [4] = '{8'h3C, 8'h00, 8'h41, 8'h2A};
        logic         s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        launch(8'h55, 8'h55, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 4; i++) begin
            launch(a[i], b[i], s[i]);
            n_cmp++;
            if ({bus.ready, flags()} !== 4'b0000) begin
                n_bad++;
                $display("FAIL b2b_accept_%0d: got %b want 0000", i, {bus.ready, flags()});
            end
            wait_done(lat);
            n_cmp++;
            if (lat !== exp_lat(a[i], b[i]) || flags() !== exp_flags(a[i], b[i], s[i])) begin
                n_bad++;
                $display("FAIL b2b_result_%0d: got lat %0d flags %b want lat %0d flags %b",
                         i, lat, flags(), exp_lat(a[i], b[i]), exp_flags(a[i], b[i], s[i]));
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = (i % 8 == 0) ? a : W'($urandom);
            s = 1'(i);
            launch(a, b, s);
            wait_done(lat);
            n_cmp++;
            if (lat !== exp_lat(a, b) || flags() !== exp_flags(a, b, s)) begin
                n_bad++;
                $display("FAIL random_%0d: p=%h q=%h sgn=%b got lat %0d flags %b want lat %0d flags %b",
                         i, a, b, s, lat, flags(), exp_lat(a, b), exp_flags(a, b, s));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_msb_decides();
        test_signed();
        test_equal_hold();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
